// File: rtl/stg2if_pkg.sv
// Shared sizes for the instruction-fetch stage: address, instruction and
// the {pc, instr, valid} fetch-bundle widths.
package stg2if_pkg;
    localparam int unsigned SIZE_ADDR = 24;
    localparam int unsigned HBIT_ADDR = SIZE_ADDR - 1;
    localparam int unsigned SIZE_DATA = 32;
    localparam int unsigned HBIT_DATA = SIZE_DATA - 1;
    localparam int unsigned SIZE_IFB  = SIZE_ADDR + SIZE_DATA + 1;
    localparam int unsigned PERF_W    = 32;
endpackage

// File: rtl/stg2if_skid.sv
// Generic 1-entry skid/hold register pair. Bit 0 of each bundle is its valid
// flag; i_clr drops both valids while leaving the data fields stale.
module stg2if_skid #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_stall,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full
);
    logic [W-1:0] r_o;
    logic [W-1:0] r_s;
    logic [W-1:0] w_o_nxt;
    logic [W-1:0] w_s_nxt;

    always_comb begin
        w_o_nxt = r_o;
        w_s_nxt = r_s;
        if (i_clr) begin
            w_o_nxt[0] = 1'b0;
            w_s_nxt[0] = 1'b0;
        end else if (!i_stall) begin
            // A held skid entry drains first; upstream is frozen meanwhile.
            if (r_s[0]) begin
                w_o_nxt    = r_s;
                w_s_nxt[0] = 1'b0;
            end else begin
                w_o_nxt = i_data;
            end
        end else if (!r_o[0]) begin
            w_o_nxt = i_data;
        end else if (!r_s[0] && i_data[0]) begin
            w_s_nxt = i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_o <= '0;
            r_s <= '0;
        end else begin
            r_o <= w_o_nxt;
            r_s <= w_s_nxt;
        end
    end

    assign o_data = r_o;
    assign o_full = r_s[0];
endmodule

// File: rtl/stg2if.sv
// Instruction-fetch stage: registers {pc, instr, valid} toward decode with a
// one-entry skid. Optional bubble counter enabled by `define STG2IF_PERF_EN.
module stg2if
    import stg2if_pkg::*;
#(
    parameter int unsigned ADDR_W  = SIZE_ADDR,
    parameter int unsigned INSTR_W = SIZE_DATA
) (
    input  logic               iw_clk,
    input  logic               iw_rst_n,
    input  logic [ADDR_W-1:0]  iw_pc,
    input  logic               iw_ia_valid,
    input  logic [INSTR_W-1:0] iw_mem_data,
    input  logic               iw_stall,
    input  logic               iw_flush,
    output logic [ADDR_W-1:0]  ow_pc,
    output logic [INSTR_W-1:0] ow_instr,
    output logic               ow_if_valid,
    output logic               ow_stall_up
`ifdef STG2IF_PERF_EN
    ,
    output logic [PERF_W-1:0]  ow_bubble_cnt
`endif
);
    localparam int unsigned IFB_W = ADDR_W + INSTR_W + 1;

    logic [IFB_W-1:0] w_in_bundle;
    logic [IFB_W-1:0] w_out_bundle;
    logic             w_s_full;

    assign w_in_bundle = {iw_pc, iw_mem_data, iw_ia_valid};

    stg2if_skid #(
        .W (IFB_W)
    ) u_skid (
        .i_clk   (iw_clk),
        .i_rst_n (iw_rst_n),
        .i_clr   (iw_flush),
        .i_stall (iw_stall),
        .i_data  (w_in_bundle),
        .o_data  (w_out_bundle),
        .o_full  (w_s_full)
    );

    assign {ow_pc, ow_instr, ow_if_valid} = w_out_bundle;
    assign ow_stall_up = w_s_full;

`ifdef STG2IF_PERF_EN
    logic              w_nxt_v;
    logic              w_bubble;
    logic [PERF_W-1:0] r_bubble_cnt;

    // Post-update output valid, reconstructed from the skid priority rules.
    assign w_nxt_v  = !iw_flush && (!iw_stall ? (w_s_full | iw_ia_valid)
                                              : (ow_if_valid | iw_ia_valid));
    assign w_bubble = !w_nxt_v || (iw_stall && ow_if_valid);

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign ow_bubble_cnt = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_stg2if.sv
// Directed self-checking bench for stg2if (bubble-counter checks only when
// STG2IF_PERF_EN is defined).
module tb_stg2if;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          ia_valid = 1'b0;
    logic [DW-1:0] mem_data = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] o_pc;
    logic [DW-1:0] o_instr;
    logic          o_valid;
    logic          o_stall_up;
`ifdef STG2IF_PERF_EN
    logic [31:0]   o_bcnt;
`endif

    int checks = 0;
    int failures = 0;

    stg2if #(
        .ADDR_W  (AW),
        .INSTR_W (DW)
    ) dut (
        .iw_clk      (clk),
        .iw_rst_n    (rst_n),
        .iw_pc       (pc),
        .iw_ia_valid (ia_valid),
        .iw_mem_data (mem_data),
        .iw_stall    (stall),
        .iw_flush    (flush),
        .ow_pc       (o_pc),
        .ow_instr    (o_instr),
        .ow_if_valid (o_valid),
        .ow_stall_up (o_stall_up)
`ifdef STG2IF_PERF_EN
        ,
        .ow_bubble_cnt (o_bcnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] p, input logic [DW-1:0] d,
                         input logic st, input logic fl);
        ia_valid = v;
        pc       = p;
        mem_data = d;
        stall    = st;
        flush    = fl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        checks++;
        if ({o_pc, o_instr, o_valid, o_stall_up} !== '0) begin
            failures++;
            $display("FAIL reset_state: got pc=%h instr=%h v=%b su=%b, want all 0",
                     o_pc, o_instr, o_valid, o_stall_up);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        drive(1'b1, 24'h000010, 32'hA1, 1'b0, 1'b0);
        step();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 24'h10 || o_instr !== 32'hA1 || o_stall_up !== 1'b0) begin
            failures++;
            $display("FAIL basic_first: got v=%b pc=%h instr=%h su=%b, want v=1 pc=000010 instr=a1 su=0",
                     o_valid, o_pc, o_instr, o_stall_up);
        end
        drive(1'b1, 24'h000011, 32'hA2, 1'b0, 1'b0);
        step();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 24'h11 || o_instr !== 32'hA2 || o_stall_up !== 1'b0) begin
            failures++;
            $display("FAIL basic_second: got v=%b pc=%h instr=%h su=%b, want v=1 pc=000011 instr=a2 su=0",
                     o_valid, o_pc, o_instr, o_stall_up);
        end
        drive(1'b0, 24'h0, 32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_bubble: got v=%b, want 0", o_valid);
        end
    endtask

    task automatic test_skid();
        drive(1'b1, 24'h20, 32'hB0, 1'b0, 1'b0);
        step();
        drive(1'b1, 24'h21, 32'hB1, 1'b1, 1'b0);
        step();
        checks++;
        if (o_pc !== 24'h20 || o_valid !== 1'b1 || o_stall_up !== 1'b1) begin
            failures++;
            $display("FAIL skid_capture: got pc=%h v=%b su=%b, want pc=000020 v=1 su=1",
                     o_pc, o_valid, o_stall_up);
        end
        drive(1'b1, 24'h22, 32'hB2, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (o_pc !== 24'h20 || o_instr !== 32'hB0 || o_valid !== 1'b1 || o_stall_up !== 1'b1) begin
                failures++;
                $display("FAIL skid_hold%0d: got pc=%h instr=%h v=%b su=%b, want pc=000020 instr=b0 v=1 su=1",
                         i, o_pc, o_instr, o_valid, o_stall_up);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (o_pc !== 24'h21 || o_instr !== 32'hB1 || o_valid !== 1'b1 || o_stall_up !== 1'b0) begin
            failures++;
            $display("FAIL skid_drain: got pc=%h instr=%h v=%b su=%b, want pc=000021 instr=b1 v=1 su=0",
                     o_pc, o_instr, o_valid, o_stall_up);
        end
        step();
        checks++;
        if (o_pc !== 24'h22 || o_instr !== 32'hB2 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL skid_next: got pc=%h instr=%h v=%b, want pc=000022 instr=b2 v=1",
                     o_pc, o_instr, o_valid);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 24'h30, 32'hC0, 1'b0, 1'b0);
        step();
        drive(1'b1, 24'h31, 32'hC1, 1'b1, 1'b0);
        step();
        drive(1'b1, 24'h32, 32'hC2, 1'b1, 1'b1);
        step();
        checks++;
        if (o_valid !== 1'b0 || o_stall_up !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear: got v=%b su=%b, want v=0 su=0", o_valid, o_stall_up);
        end
        drive(1'b1, 24'h40, 32'hD0, 1'b0, 1'b0);
        step();
        checks++;
        if (o_pc !== 24'h40 || o_instr !== 32'hD0 || o_valid !== 1'b1 || o_stall_up !== 1'b0) begin
            failures++;
            $display("FAIL flush_refetch: got pc=%h instr=%h v=%b su=%b, want pc=000040 instr=d0 v=1 su=0",
                     o_pc, o_instr, o_valid, o_stall_up);
        end
    endtask

    task automatic test_bubbles();
        drive(1'b1, 24'h50, 32'hE0, 1'b0, 1'b0);
        step();
        drive(1'b0, 24'h77, 32'hEE, 1'b1, 1'b0);
        step();
        checks++;
        if (o_pc !== 24'h50 || o_valid !== 1'b1 || o_stall_up !== 1'b0) begin
            failures++;
            $display("FAIL bubble_no_skid: got pc=%h v=%b su=%b, want pc=000050 v=1 su=0",
                     o_pc, o_valid, o_stall_up);
        end
        drive(1'b1, 24'h51, 32'hE1, 1'b0, 1'b0);
        step();
        checks++;
        if (o_pc !== 24'h51 || o_instr !== 32'hE1 || o_valid !== 1'b1 || o_stall_up !== 1'b0) begin
            failures++;
            $display("FAIL bubble_after: got pc=%h instr=%h v=%b su=%b, want pc=000051 instr=e1 v=1 su=0",
                     o_pc, o_instr, o_valid, o_stall_up);
        end
        // Empty output register accepts even while decode stalls.
        drive(1'b0, 24'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(1'b1, 24'h60, 32'hF0, 1'b1, 1'b0);
        step();
        checks++;
        if (o_pc !== 24'h60 || o_valid !== 1'b1 || o_stall_up !== 1'b0) begin
            failures++;
            $display("FAIL bubble_unblock: got pc=%h v=%b su=%b, want pc=000060 v=1 su=0",
                     o_pc, o_valid, o_stall_up);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 24'h70, 32'h70, 1'b0, 1'b0);
        step();
        drive(1'b1, 24'h71, 32'h71, 1'b1, 1'b0);
        step();
        checks++;
        if (o_stall_up !== 1'b1) begin
            failures++;
            $display("FAIL arst_setup: got su=%b, want 1", o_stall_up);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_stall_up !== 1'b0 || o_pc !== '0) begin
            failures++;
            $display("FAIL arst_immediate: got v=%b su=%b pc=%h, want v=0 su=0 pc=000000",
                     o_valid, o_stall_up, o_pc);
        end
        drive(1'b1, 24'h72, 32'h72, 1'b0, 1'b1);
        step();
        rst_n = 1'b1;
        drive(1'b0, 24'h0, 32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (o_valid !== 1'b0 || o_stall_up !== 1'b0) begin
            failures++;
            $display("FAIL arst_release: got v=%b su=%b, want v=0 su=0", o_valid, o_stall_up);
        end
    endtask

`ifdef STG2IF_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        drive(1'b1, 24'h80, 32'h80, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        step();
        drive(1'b0, 24'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        stall = 1'b0;
        step();
        step();
        checks++;
        if (o_bcnt !== 32'd6) begin
            failures++;
            $display("FAIL perf_count: got %0d, want 6", o_bcnt);
        end
        force dut.r_bubble_cnt = 32'hFFFFFFFF;
        #1 release dut.r_bubble_cnt;
        step();
        checks++;
        if (o_bcnt !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL perf_saturate: got %h, want ffffffff", o_bcnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_skid();
        test_flush();
        test_bubbles();
        test_async_reset();
`ifdef STG2IF_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
